// File: rtl/sel_input_loader_if.sv
// Handshake/bus bundle between the select-input loader and its environment.
// The loader connects through the slave modport; the driver of the raw
// button/switches and the consuming counter FSM use the master modport.
interface sel_input_loader_if #(
  parameter int DW = 8
);
  logic          v_i;
  logic [DW-1:0] din_i;
  logic          ack_i;
  logic [DW-1:0] n1_o;
  logic [DW-1:0] n2_o;
  logic          valid_o;
  logic          v_pulse_o;
  logic [1:0]    state_o;

  modport master (
    output v_i, din_i, ack_i,
    input  n1_o, n2_o, valid_o, v_pulse_o, state_o
  );

  modport slave (
    input  v_i, din_i, ack_i,
    output n1_o, n2_o, valid_o, v_pulse_o, state_o
  );
endinterface

// File: rtl/sel_input_loader.sv
// sel_input_loader: synchronises and debounces the select button, then turns
// two debounced presses into a latched {n1, n2} operand pair for the counter FSM.
// Optional feature macro: LOADER_SORT_EN (orders the pair so n1 <= n2).
//
// Handshake: valid_o is high exactly while the FSM sits in VALID and n1_o/n2_o
// are a complete pair. The consumer raises ack_i for a cycle when it has taken
// the pair; ack_i is only looked at while valid_o=1, and the pair registers keep
// their values after the ack until the next load overwrites them.
module sel_input_loader #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int DW          = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  sel_input_loader_if.slave bus
);

  localparam int DB_RAW = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DB_CNT = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int CW     = $clog2(DB_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GOT_N1 = 2'd1,
    ST_VALID  = 2'd2,
    ST_SPARE  = 2'd3
  } state_t;

  logic          v_meta, v_sync;
  logic [DW-1:0] din_meta, din_sync;
  logic          s_q, s_prev;
  logic [CW-1:0] c_q;
  logic          pulse_q;

  state_t        state_q, state_d;
  logic [DW-1:0] n1_q, n1_d;
  logic [DW-1:0] n2_q, n2_d;
  logic          valid_q;

  // Two-flop synchronisers for the asynchronous button and switch bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_meta   <= 1'b0;
      v_sync   <= 1'b0;
      din_meta <= '0;
      din_sync <= '0;
    end else begin
      v_meta   <= bus.v_i;
      v_sync   <= v_meta;
      din_meta <= bus.din_i;
      din_sync <= din_meta;
    end
  end

  // Debounce: the stable level only flips after DB_CNT consecutive disagreeing
  // cycles; the press strobe is registered one cycle after the 0->1 flip.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q     <= 1'b0;
      s_prev  <= 1'b0;
      c_q     <= '0;
      pulse_q <= 1'b0;
    end else begin
      s_prev  <= s_q;
      pulse_q <= s_q & ~s_prev;
      if (v_sync != s_q) begin
        if (c_q == CW'(DB_CNT - 1)) begin
          s_q <= ~s_q;
          c_q <= '0;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end else begin
        c_q <= '0;
      end
    end
  end

  // Loader FSM next-state and operand-load logic.
  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    case (state_q)
      ST_IDLE: begin
        if (pulse_q) begin
          n1_d    = din_sync;
          state_d = ST_GOT_N1;
        end
      end
      ST_GOT_N1: begin
        if (pulse_q) begin
`ifdef LOADER_SORT_EN
          // Swap on load so the smaller operand always ends up in n1.
          if (din_sync < n1_q) begin
            n1_d = din_sync;
            n2_d = n1_q;
          end else begin
            n2_d = din_sync;
          end
`else
          n2_d = din_sync;
`endif
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        // A press arriving here is dropped; an ack (even with a press) releases the pair.
        if (bus.ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loader FSM state, operand and valid registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      n1_q    <= '0;
      n2_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      valid_q <= (state_d == ST_VALID);
    end
  end

  assign bus.n1_o      = n1_q;
  assign bus.n2_o      = n2_q;
  assign bus.valid_o   = valid_q;
  assign bus.v_pulse_o = pulse_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_sel_input_loader.sv
// Bench for sel_input_loader with CLK_HZ=1000, DEBOUNCE_MS=4 (DB_CNT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sel_input_loader;

  localparam int DW     = 8;
  localparam int DB_CNT = 4;

  logic clk;
  logic rst;

  sel_input_loader_if #(.DW(DW)) bus ();

  sel_input_loader #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .DW          (DW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int checks_total  = 0;
  int checks_passed = 0;
  int pulse_cnt     = 0;
  logic [2*DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      checks_passed++;
    end
  endtask

  // Expected pair for presses a then b.
  function automatic logic [2*DW-1:0] exp_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef LOADER_SORT_EN
    if (b < a) return {b, a};
`endif
    return {a, b};
  endfunction

  // Scoreboard: count press strobes, pop an expected pair on each valid rise.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.v_pulse_o === 1'b1) pulse_cnt++;
    if (bus.valid_o === 1'b1 && !valid_prev) begin
      check("pair_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("pair", {bus.n1_o, bus.n2_o}, exp_q.pop_front());
    end
    valid_prev = (bus.valid_o === 1'b1);
  end

  // Driver tasks
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for the press strobe; optionally raise ack in that same cycle.
  task automatic wait_pulse(input string tag, input bit ack_on_pulse, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (bus.v_pulse_o === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
    if (seen && ack_on_pulse) begin
      bus.ack_i = 1'b1;
      @(negedge clk);
      bus.ack_i = 1'b0;
    end
  endtask

  task automatic press(input logic [DW-1:0] d, input bit ack_on_pulse);
    int lat;
    bus.din_i = d;
    bus.v_i   = 1'b1;
    wait_pulse("press_pulse", ack_on_pulse, lat);
    bus.v_i = 1'b0;
    repeat (DB_CNT + 6) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic [DW-1:0] n1, input logic [DW-1:0] n2,
                               input logic valid, input logic [1:0] st);
    check({tag, "_n1"}, 32'(bus.n1_o), 32'(n1));
    check({tag, "_n2"}, 32'(bus.n2_o), 32'(n2));
    check({tag, "_valid"}, 32'(bus.valid_o), 32'(valid));
    check({tag, "_state"}, 32'(bus.state_o), 32'(st));
  endtask

  initial begin
    int lat;
    int base;
    rst       = 1'b1;
    bus.v_i   = 1'b0;
    bus.din_i = '0;
    bus.ack_i = 1'b0;

    // 1. Reset with button held and switches all ones.
    @(negedge clk);
    bus.v_i   = 1'b1;
    bus.din_i = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs("rst_hold", 8'h00, 8'h00, 1'b0, 2'd0);
      check("rst_hold_pulse", 32'(bus.v_pulse_o), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_outputs("rst_release", 8'h00, 8'h00, 1'b0, 2'd0);
    check("rst_release_pulse", 32'(bus.v_pulse_o), 32'd0);
    // Held button counts as a fresh press after release.
    wait_pulse("held_press_pulse", 1'b0, lat);
    @(negedge clk);
    check_outputs("held_press", 8'hFF, 8'h00, 1'b0, 2'd1);
    bus.v_i = 1'b0;
    do_reset(2);
    repeat (DB_CNT + 6) @(negedge clk);
    check_outputs("rst_clean", 8'h00, 8'h00, 1'b0, 2'd0);

    // 2. Bounce shorter than the debounce window, then a clean hold.
    base      = pulse_cnt;
    bus.din_i = 8'h12;
    bus.v_i   = 1'b1;
    repeat (3) @(negedge clk);
    bus.v_i = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_no_pulse", 32'(pulse_cnt - base), 32'd0);
    check("bounce_state", 32'(bus.state_o), 32'd0);
    bus.v_i = 1'b1;
    wait_pulse("hold_pulse", 1'b0, lat);
    check("pulse_latency", 32'(lat), 32'd7);
    repeat (10) @(negedge clk);
    check("single_pulse", 32'(pulse_cnt - base), 32'd1);
    bus.v_i = 1'b0;
    repeat (DB_CNT + 6) @(negedge clk);

    // 3. Second press completes the pair; ack releases it.
    exp_q.push_back(exp_pair(8'h12, 8'h34));
    press(8'h34, 1'b0);
    check_outputs("pair_load", 8'h12, 8'h34, 1'b1, 2'd2);
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    check_outputs("after_ack", 8'h12, 8'h34, 1'b0, 2'd0);
    // Ack outside VALID changes nothing.
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    @(negedge clk);
    check_outputs("idle_ack", 8'h12, 8'h34, 1'b0, 2'd0);

    // 4. Press while VALID is ignored; press with ack in the same cycle drops the press.
    press(8'h77, 1'b0);
    exp_q.push_back(exp_pair(8'h77, 8'h88));
    press(8'h88, 1'b0);
    press(8'h56, 1'b0);
    check_outputs("valid_hold", 8'h77, 8'h88, 1'b1, 2'd2);
    press(8'h99, 1'b1);
    check_outputs("ack_wins", 8'h77, 8'h88, 1'b0, 2'd0);

    // 5. Reset mid-sequence discards the partial pair.
    press(8'hCC, 1'b0);
    check_outputs("mid_got_n1", 8'hCC, 8'h88, 1'b0, 2'd1);
    do_reset(2);
    @(negedge clk);
    check_outputs("mid_reset", 8'h00, 8'h00, 1'b0, 2'd0);
    press(8'hA0, 1'b0);
    exp_q.push_back(exp_pair(8'hA0, 8'h0B));
    press(8'h0B, 1'b0);
    check("after_reset_pair", {bus.n1_o, bus.n2_o}, exp_pair(8'hA0, 8'h0B));
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;

    // 6. Descending pair: ordering depends on LOADER_SORT_EN.
    press(8'h50, 1'b0);
    exp_q.push_back(exp_pair(8'h50, 8'h20));
    press(8'h20, 1'b0);
`ifdef LOADER_SORT_EN
    check_outputs("sort_pair", 8'h20, 8'h50, 1'b1, 2'd2);
`else
    check_outputs("order_pair", 8'h50, 8'h20, 1'b1, 2'd2);
`endif

    // Random pairs
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      a = DW'($urandom_range(0, 255));
      b = DW'($urandom_range(0, 255));
      bus.ack_i = 1'b1;
      @(negedge clk);
      bus.ack_i = 1'b0;
      press(a, 1'b0);
      exp_q.push_back(exp_pair(a, b));
      press(b, 1'b0);
      check("rand_valid", 32'(bus.valid_o), 32'd1);
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
